// File: rtl/spi_sensor_responder.sv
// SPI mode-0 sensor responder: 16-bit commands in, one-frame-pipelined 16-bit responses out.
// Define SPI_RESP_FRAME_ERR_EN to count aborted frames on err_cnt; otherwise err_cnt is tied to zero.
module spi_sensor_responder #(
  parameter logic [7:0] CHIP_ID     = 8'h01,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CS_b,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        frame_done,
  output logic [15:0] last_cmd,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic        cs_prev, sclk_prev;
  logic        cs_s, sclk_s, mosi_s;
  logic        cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic        abort;
  logic [15:0] rx_reg, tx_reg, decode_resp;
  logic [4:0]  bit_cnt;
  logic [9:0]  conv_cnt;
  logic [7:0]  regs [64];
  logic        miso_q;
  logic [5:0]  addr;

  // CS_b synchronizer resets high so reset release never looks like a select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_prev   <= 1'b1;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_b};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      cs_prev   <= cs_s;
      sclk_prev <= sclk_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_prev & ~cs_s;
  assign cs_rise   = ~cs_prev & cs_s;
  assign sclk_rise = ~sclk_prev & sclk_s;
  assign sclk_fall = sclk_prev & ~sclk_s;
  assign abort     = (state == SHIFT) && cs_rise && (bit_cnt != 5'd16);
  assign addr      = rx_reg[13:8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall) state_next = SHIFT;
      SHIFT:   if (cs_rise) state_next = (bit_cnt == 5'd16) ? DECODE : IDLE;
      DECODE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    decode_resp = '0;
    case (rx_reg[15:14])
      2'b00:   decode_resp = {addr, conv_cnt};
      2'b10:   decode_resp = {8'hFF, rx_reg[7:0]};
      2'b11:   decode_resp = {8'h00, (addr == 6'd63) ? CHIP_ID : regs[addr]};
      default: decode_resp = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_reg   <= '0;
      rx_reg   <= '0;
      bit_cnt  <= '0;
      conv_cnt <= '0;
      miso_q   <= 1'b0;
      last_cmd <= '0;
      for (int i = 0; i < 64; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            bit_cnt <= '0;
            miso_q  <= tx_reg[15];
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            miso_q <= 1'b0;
            if (abort) tx_reg <= '0;
          end else begin
            if (sclk_rise) begin
              rx_reg <= {rx_reg[14:0], mosi_s};
              if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
            end
            if (sclk_fall) begin
              tx_reg <= {tx_reg[14:0], 1'b0};
              miso_q <= tx_reg[14];
            end
          end
        end
        DECODE: begin
          tx_reg   <= decode_resp;
          last_cmd <= rx_reg;
          if (rx_reg[15:14] == 2'b00) conv_cnt <= conv_cnt + 10'd1;
          if (rx_reg[15:14] == 2'b10 && addr != 6'd63) regs[addr] <= rx_reg[7:0];
        end
        default: ;
      endcase
    end
  end

  // Gated by the raw pin so MISO is quiet the moment the master deselects.
  assign MISO       = miso_q & ~CS_b;
  assign frame_done = (state == DECODE);

`ifdef SPI_RESP_FRAME_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          err_cnt <= '0;
    else if (abort && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`else
  assign err_cnt = 8'h00;
`endif

endmodule
